// File: rtl/fb_scanout.sv
// Framebuffer scan-out: reads a finished frame from single-port SRAM and streams it
// in raster order through a 2-entry skid FIFO with a valid/ready handshake.

module fb_scanout #(
    parameter int FB_W = 64,
    parameter int FB_H = 64,
    parameter int AW   = 12,
    parameter int DW   = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    FB_CEN,
    output logic                    FB_WEN,
    output logic [AW-1:0]           FB_A,
    input  logic [DW-1:0]           FB_Q,
    output logic                    px_valid,
    input  logic                    px_ready,
    output logic [DW-1:0]           px_data,
    output logic [$clog2(FB_W)-1:0] px_x,
    output logic [$clog2(FB_H)-1:0] px_y,
    output logic                    px_sol,
    output logic                    px_eof
);

    localparam int XW = $clog2(FB_W);
    localparam int YW = $clog2(FB_H);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          sol;
        logic          eof;
    } entry_t;

    state_t        state_q, state_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [AW-1:0] fb_a_q;
    logic          inflight_q;
    entry_t        fifo_q [2];
    logic          rd_ptr_q, wr_ptr_q;
    logic [1:0]    cnt_q;

    logic          pop, push, issue;
    logic [2:0]    demand;
    entry_t        head, incoming;

    assign head     = fifo_q[rd_ptr_q];
    assign px_valid = (cnt_q != 2'd0);
    assign pop      = px_valid & px_ready;
    assign push     = inflight_q;

    // Space check counts the read still in flight so the FIFO can never overflow.
    assign demand = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
    assign issue  = (state_q == RUN) && (demand < 3'd2);

    assign FB_CEN = ~issue;
    assign FB_WEN = 1'b1;
    assign FB_A   = issue ? raddr_q : fb_a_q;

    // The address register still holds the issued address when its data returns.
    assign incoming.data = FB_Q;
    assign incoming.x    = fb_a_q[XW-1:0];
    assign incoming.y    = fb_a_q[AW-1:XW];
    assign incoming.sol  = (fb_a_q[XW-1:0] == '0);
    assign incoming.eof  = &fb_a_q;

    assign px_data    = head.data;
    assign px_x       = head.x;
    assign px_y       = head.y;
    assign px_sol     = head.sol;
    assign px_eof     = head.eof;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    raddr_d = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    if (raddr_q == '1) begin
                        state_d = DRAIN;
                    end else begin
                        raddr_d = raddr_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (pop && head.eof) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_a_q     <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            fb_a_q     <= FB_A;
            inflight_q <= issue;
            if (push) begin
                fifo_q[wr_ptr_q] <= incoming;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout: SRAM model plus a raster-order scoreboard
// derived directly from the frame contents.

module tb_fb_scanout;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic        FB_CEN;
    logic        FB_WEN;
    logic [11:0] FB_A;
    logic [11:0] FB_Q;
    logic        px_valid;
    logic        px_ready;
    logic [11:0] px_data;
    logic [5:0]  px_x;
    logic [5:0]  px_y;
    logic        px_sol;
    logic        px_eof;

    logic [11:0] mem [4096];

    int   checks = 0;
    int   errors = 0;
    int   tickNo = 0;
    int   issued, popped, doneCount, doneTick;
    int   firstCenTick, lastCenTick, firstHsTick, lastHsTick;
    int   maxOut = 0;
    int   wenBad = 0;
    int   startTick;
    logic busyAtDone;

    fb_scanout dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .FB_CEN     (FB_CEN),
        .FB_WEN     (FB_WEN),
        .FB_A       (FB_A),
        .FB_Q       (FB_Q),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_data    (px_data),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_sol     (px_sol),
        .px_eof     (px_eof)
    );

    always #5 clk = ~clk;

    // Single-port SRAM: data appears the cycle after a chip-enabled read.
    always @(posedge clk) begin
        if (FB_CEN === 1'b0) FB_Q <= mem[FB_A];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetScore();
        issued       = 0;
        popped       = 0;
        doneCount    = 0;
        doneTick     = -1;
        firstCenTick = -1;
        lastCenTick  = -1;
        firstHsTick  = -1;
        lastHsTick   = -1;
        busyAtDone   = 1'b0;
    endtask

    // One clock cycle: drive inputs just after the edge, observe just before the next.
    task automatic applyStimulus(input logic rdy, input logic st);
        logic [31:0] expData;
        @(posedge clk);
        #1;
        px_ready = rdy;
        start    = st;
        #1;
        tickNo++;
        if (FB_WEN !== 1'b1) wenBad++;
        if (FB_CEN === 1'b0) begin
            checkOutput("fb_a_order", 32'(FB_A), 32'(issued));
            if (firstCenTick < 0) firstCenTick = tickNo;
            lastCenTick = tickNo;
            issued++;
        end
        if (px_valid === 1'b1 && px_ready === 1'b1) begin
            expData = (popped < 4096) ? 32'(mem[popped]) : 32'hFFFF_FFFF;
            checkOutput("px_data", 32'(px_data), expData);
            checkOutput("px_x", 32'(px_x), 32'(popped % 64));
            checkOutput("px_y", 32'(px_y), 32'(popped / 64));
            checkOutput("px_sol", 32'(px_sol), 32'(popped % 64 == 0));
            checkOutput("px_eof", 32'(px_eof), 32'(popped == 4095));
            if (popped == 0) firstHsTick = tickNo;
            lastHsTick = tickNo;
            popped++;
        end
        if (issued - popped > maxOut) maxOut = issued - popped;
        if (frame_done === 1'b1) begin
            doneCount++;
            doneTick   = tickNo;
            busyAtDone = busy;
        end
    endtask

    initial begin
        int   n;
        int   stallBad;
        logic nextStart;
        logic st;

        reset    = 1'b0;
        start    = 1'b0;
        px_ready = 1'b0;
        FB_Q     = '0;
        for (int a = 0; a < 4096; a++) mem[a] = 12'(a);
        resetScore();

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_cen", 32'(FB_CEN), 32'd1);
        checkOutput("rst_wen", 32'(FB_WEN), 32'd1);
        checkOutput("rst_addr", 32'(FB_A), 32'd0);
        checkOutput("rst_valid", 32'(px_valid), 32'd0);
        checkOutput("rst_data", 32'(px_data), 32'd0);
        checkOutput("rst_x", 32'(px_x), 32'd0);
        checkOutput("rst_y", 32'(px_y), 32'd0);
        checkOutput("rst_sol", 32'(px_sol), 32'd0);
        checkOutput("rst_eof", 32'(px_eof), 32'd0);
        reset = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b0);

        // Full frame, ready always high, mem[a] = a
        $display("[TB] frame 1: streaming with px_ready high");
        resetScore();
        applyStimulus(1'b1, 1'b1);
        startTick = tickNo;
        applyStimulus(1'b1, 1'b0);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        n = 0;
        while (doneCount == 0 && n < 5000) begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end
        repeat (3) applyStimulus(1'b1, 1'b0);
        checkOutput("f1_first_cen", 32'(firstCenTick), 32'(startTick + 1));
        checkOutput("f1_last_cen", 32'(lastCenTick), 32'(startTick + 4096));
        checkOutput("f1_issued", 32'(issued), 32'd4096);
        checkOutput("f1_first_valid", 32'(firstHsTick), 32'(startTick + 3));
        checkOutput("f1_last_hs", 32'(lastHsTick), 32'(startTick + 4098));
        checkOutput("f1_done_tick", 32'(doneTick), 32'(startTick + 4099));
        checkOutput("f1_done_count", 32'(doneCount), 32'd1);
        checkOutput("f1_busy_at_done", 32'(busyAtDone), 32'd1);
        checkOutput("f1_busy_after", 32'(busy), 32'd0);
        checkOutput("f1_popped", 32'(popped), 32'd4096);

        // Backpressure stall right at the first pixel
        $display("[TB] frame 2: 20-cycle stall at first pixel");
        for (int a = 0; a < 4096; a++) mem[a] = 12'($urandom);
        resetScore();
        applyStimulus(1'b0, 1'b1);
        startTick = tickNo;
        n = 0;
        while (px_valid !== 1'b1 && n < 10) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        checkOutput("bp_first_valid", 32'(tickNo), 32'(startTick + 3));
        stallBad = 0;
        repeat (20) begin
            applyStimulus(1'b0, 1'b0);
            if (px_valid !== 1'b1 || px_data !== mem[0]) stallBad++;
        end
        checkOutput("bp_reads_during_stall", 32'(issued), 32'd2);
        checkOutput("bp_head_stable", 32'(stallBad), 32'd0);
        n = 0;
        while (doneCount == 0 && n < 5000) begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end
        checkOutput("bp_popped", 32'(popped), 32'd4096);
        checkOutput("bp_issued", 32'(issued), 32'd4096);
        checkOutput("bp_done_count", 32'(doneCount), 32'd1);

        // Random ready, stray starts mid-frame and in the DONE cycle
        $display("[TB] frame 3: random px_ready with stray starts");
        for (int a = 0; a < 4096; a++) mem[a] = 12'($urandom);
        resetScore();
        applyStimulus(1'b1, 1'b1);
        nextStart = 1'b0;
        n = 0;
        while (doneCount == 0 && n < 20000) begin
            st = nextStart || (n == 300) || (n == 2500);
            applyStimulus(1'($urandom_range(0, 1)), st);
            nextStart = (px_valid === 1'b1 && px_ready === 1'b1 && px_eof === 1'b1);
            n++;
        end
        repeat (10) applyStimulus(1'b1, 1'b0);
        checkOutput("rr_issued", 32'(issued), 32'd4096);
        checkOutput("rr_popped", 32'(popped), 32'd4096);
        checkOutput("rr_done_count", 32'(doneCount), 32'd1);
        checkOutput("rr_busy_after", 32'(busy), 32'd0);
        checkOutput("rr_valid_after", 32'(px_valid), 32'd0);

        // Asynchronous reset in the middle of a frame
        $display("[TB] frame 4: reset at pixel 1000, then a fresh frame");
        for (int a = 0; a < 4096; a++) mem[a] = 12'($urandom);
        resetScore();
        applyStimulus(1'b1, 1'b1);
        n = 0;
        while (popped < 1000 && n < 3000) begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end
        checkOutput("mr_pre_popped", 32'(popped), 32'd1000);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mr_busy", 32'(busy), 32'd0);
        checkOutput("mr_valid", 32'(px_valid), 32'd0);
        checkOutput("mr_cen", 32'(FB_CEN), 32'd1);
        checkOutput("mr_addr", 32'(FB_A), 32'd0);
        checkOutput("mr_data", 32'(px_data), 32'd0);
        checkOutput("mr_x", 32'(px_x), 32'd0);
        checkOutput("mr_frame_done", 32'(frame_done), 32'd0);
        checkOutput("mr_eof", 32'(px_eof), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        resetScore();
        repeat (5) applyStimulus(1'b1, 1'b0);
        checkOutput("mr_no_resume", 32'(issued), 32'd0);
        applyStimulus(1'b1, 1'b1);
        startTick = tickNo;
        n = 0;
        while (doneCount == 0 && n < 5000) begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end
        checkOutput("mr_first_cen", 32'(firstCenTick), 32'(startTick + 1));
        checkOutput("mr_popped", 32'(popped), 32'd4096);
        checkOutput("mr_issued", 32'(issued), 32'd4096);
        checkOutput("mr_done_count", 32'(doneCount), 32'd1);

        checkOutput("fb_wen_const", 32'(wenBad), 32'd0);
        checkOutput("max_outstanding", 32'(maxOut <= 2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
